// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the scanning N:1 multiplexer.
//   state_t   : FSM state encoding (IDLE, MAN, SCAN)
//   MODE_*    : encodings of the 'mode' input
//   first_set : lowest set index of a mask of up to MAX_CH bits
package mux_scan_pkg;

   localparam int unsigned MAX_CH = 64;
   localparam int unsigned MAX_CW = 6;

   localparam logic MODE_MAN  = 1'b0;
   localparam logic MODE_SCAN = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAN  = 2'd1,
      SCAN = 2'd2
   } state_t;

   // Lowest set bit index; 0 when the mask is empty.
   function automatic logic [MAX_CW-1:0] first_set(input logic [MAX_CH-1:0] mask);
      logic [MAX_CW-1:0] idx;
      logic              found;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_CH; i++) begin
         if (mask[i] && !found) begin
            idx   = MAX_CW'(i);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Circular priority search: next set mask bit strictly above 'cur',
// wrapping to the lowest set bit when none is higher.
//   mask      in  CH  candidate channels
//   cur       in  CW  current channel index
//   nxt_c     out CW  next channel (cur when mask is empty)
//   any_set_c out 1   mask has at least one bit set
//   wrapped_c out 1   search wrapped round (nxt_c <= cur)
module mux_next_ch
   import mux_scan_pkg::*;
#(
   parameter  int unsigned CH = 16,
   localparam int unsigned CW = $clog2(CH)
) (
   input  logic [CH-1:0] mask,
   input  logic [CW-1:0] cur,
   output logic [CW-1:0] nxt_c,
   output logic          any_set_c,
   output logic          wrapped_c
);

   logic [CW-1:0] hi_idx;
   logic [CW-1:0] lo_idx;
   logic          hi_found;

   always_comb begin
      hi_idx   = '0;
      hi_found = 1'b0;
      for (int i = 0; i < int'(CH); i++) begin
         if (mask[i] && (CW'(i) > cur) && !hi_found) begin
            hi_idx   = CW'(i);
            hi_found = 1'b1;
         end
      end
      lo_idx    = CW'(first_set(MAX_CH'(mask)));
      any_set_c = |mask;
      wrapped_c = any_set_c && !hi_found;
      if (!any_set_c)    nxt_c = cur;
      else if (hi_found) nxt_c = hi_idx;
      else               nxt_c = lo_idx;
   end

endmodule

// File: rtl/mux_scan_nto1.sv
// Registered N:1 multiplexer with manual select and round-robin auto-scan.
//   clk, rst : clock, asynchronous active-high reset
//   en       : block enable (low -> IDLE, valid deasserted, outputs held)
//   mode     : 0 manual select, 1 auto-scan
//   sel      : manual channel index
//   mask     : scan channel enables
//   data_in  : packed channels, channel i at [i*W +: W]
//   dout     : selected data (registered)
//   ch_out   : channel driving dout
//   valid    : dout/ch_out meaningful
//   wrap     : one-cycle pulse when the scan wraps round
//   par      : even parity of dout (only with MUX_SCAN_PARITY_EN defined)
module mux_scan_nto1
   import mux_scan_pkg::*;
#(
   parameter  int unsigned CH    = 16,
   parameter  int unsigned W     = 1,
   parameter  int unsigned DWELL = 1,
   localparam int unsigned CW    = $clog2(CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            mode,
   input  logic [CW-1:0]   sel,
   input  logic [CH-1:0]   mask,
   input  logic [CH*W-1:0] data_in,
   output logic [W-1:0]    dout,
   output logic [CW-1:0]   ch_out,
   output logic            valid,
   output logic            wrap
`ifdef MUX_SCAN_PARITY_EN
   ,
   output logic            par
`endif
);

   localparam int unsigned     DCW   = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DCW-1:0] DLAST = DCW'(DWELL - 1);

   state_t         state, state_nxt;
   logic [DCW-1:0] cnt, cnt_nxt;
   logic [W-1:0]   dout_nxt;
   logic [CW-1:0]  ch_nxt;
   logic           valid_nxt;
   logic           wrap_nxt;

   logic [CW-1:0]  scan_nxt_c;
   logic           scan_any_c;
   logic           scan_wrap_c;
   logic [CW-1:0]  first_ch_c;

   // Data of channel idx; constant slices keep the mux in range for any CH.
   function automatic logic [W-1:0] pick(input logic [CH*W-1:0] d, input logic [CW-1:0] idx);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < int'(CH); i++)
         if (CW'(i) == idx) r = d[i*W +: W];
      return r;
   endfunction

   // True when idx names an existing channel (matters for non-power-of-two CH).
   function automatic logic in_range(input logic [CW-1:0] idx);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < int'(CH); i++)
         if (CW'(i) == idx) ok = 1'b1;
      return ok;
   endfunction

   mux_next_ch #(.CH(CH)) u_next (
      .mask      (mask),
      .cur       (ch_out),
      .nxt_c     (scan_nxt_c),
      .any_set_c (scan_any_c),
      .wrapped_c (scan_wrap_c)
   );

   assign first_ch_c = CW'(first_set(MAX_CH'(mask)));

   // Next state and next register values.
   always_comb begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      dout_nxt  = dout;
      ch_nxt    = ch_out;
      valid_nxt = 1'b0;
      wrap_nxt  = 1'b0;

      if (en) begin
         case (mode)
            MODE_MAN:  state_nxt = MAN;
            MODE_SCAN: state_nxt = SCAN;
            default:   state_nxt = IDLE;
         endcase
      end

      case (state_nxt)
         MAN: begin
            if (in_range(sel)) begin
               dout_nxt  = pick(data_in, sel);
               ch_nxt    = sel;
               valid_nxt = 1'b1;
            end else begin
               dout_nxt  = '0;
            end
         end
         SCAN: begin
            if (!scan_any_c) begin
               // Empty mask: park, counter held at 0, invalid.
            end else if (state != SCAN || !valid) begin
               // (Re)start at the lowest enabled channel.
               ch_nxt    = first_ch_c;
               dout_nxt  = pick(data_in, first_ch_c);
               valid_nxt = 1'b1;
            end else if (cnt == DLAST) begin
               ch_nxt    = scan_nxt_c;
               dout_nxt  = pick(data_in, scan_nxt_c);
               wrap_nxt  = scan_wrap_c;
               valid_nxt = 1'b1;
            end else begin
               cnt_nxt   = cnt + DCW'(1);
               dout_nxt  = pick(data_in, ch_out);
               valid_nxt = 1'b1;
            end
         end
         IDLE:    ;
         default: ;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         dout   <= '0;
         ch_out <= '0;
         valid  <= 1'b0;
         wrap   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         dout   <= dout_nxt;
         ch_out <= ch_nxt;
         valid  <= valid_nxt;
         wrap   <= wrap_nxt;
      end
   end

`ifdef MUX_SCAN_PARITY_EN
   // Parity tracks dout; out-of-range selects force dout, hence par, to 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) par <= 1'b0;
      else     par <= ^dout_nxt;
   end
`endif

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Bench for mux_scan_nto1: DUT A (CH=12, W=4, DWELL=3) and DUT B
// (CH=16, W=1, DWELL=1) share stimulus; each table row names the DUT checked.
module tb_mux_scan_nto1;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        mode;
   logic [3:0]  sel;
   logic [15:0] mask;
   logic [47:0] data;

   logic [3:0]  dout_a, ch_a;
   logic        valid_a, wrap_a;
   logic [0:0]  dout_b;
   logic [3:0]  ch_b;
   logic        valid_b, wrap_b;
`ifdef MUX_SCAN_PARITY_EN
   logic        par_a, par_b;
`endif

   always #5 clk = ~clk;

   mux_scan_nto1 #(.CH(12), .W(4), .DWELL(3)) dut_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
      .mask(mask[11:0]), .data_in(data),
      .dout(dout_a), .ch_out(ch_a), .valid(valid_a), .wrap(wrap_a)
`ifdef MUX_SCAN_PARITY_EN
      , .par(par_a)
`endif
   );

   mux_scan_nto1 #(.CH(16), .W(1), .DWELL(1)) dut_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
      .mask(mask), .data_in(data[15:0]),
      .dout(dout_b), .ch_out(ch_b), .valid(valid_b), .wrap(wrap_b)
`ifdef MUX_SCAN_PARITY_EN
      , .par(par_b)
`endif
   );

   typedef struct {
      logic        tgt;    // 0: DUT A, 1: DUT B
      logic        en;
      logic        mode;
      logic [3:0]  sel;
      logic [15:0] mask;
      logic [47:0] data;
      logic        chk_d;  // compare dout (and par)
      logic [3:0]  e_dout;
      logic [3:0]  e_ch;
      logic        e_valid;
      logic        e_wrap;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
      end
   endtask

   // Channel i of DUT A carries value i; channel k (if >= 0) carries 4'hF.
   function automatic logic [47:0] ramp(input int k);
      logic [47:0] r;
      for (int i = 0; i < 12; i++) r[i*4 +: 4] = (i == k) ? 4'hF : 4'(i);
      return r;
   endfunction

   task automatic add(input int tgt, input int e, input int m, input int s,
                      input logic [15:0] mk, input logic [47:0] d,
                      input int chk, input int ed, input int ec, input int ev, input int ew);
      vec_t v;
      v.tgt = 1'(tgt);  v.en = 1'(e);  v.mode = 1'(m);  v.sel = 4'(s);
      v.mask = mk;      v.data = d;    v.chk_d = 1'(chk);
      v.e_dout = 4'(ed); v.e_ch = 4'(ec); v.e_valid = 1'(ev); v.e_wrap = 1'(ew);
      tbl.push_back(v);
   endtask

   // Scan row on DUT A with valid expected.
   task automatic sa(input logic [15:0] mk, input logic [47:0] d, input int ed, input int ec, input int ew);
      add(0, 1, 1, 0, mk, d, 1, ed, ec, 1, ew);
   endtask

   initial begin
      vec_t        ev;
      logic [15:0] ma;
      logic [47:0] r;
      ma = 16'h00A5;   // channels 0,2,5,7
      r  = ramp(-1);

      // Manual select, out-of-range select
      add(0, 1, 0, 5,  ma, r, 1, 5, 5, 1, 0);
      add(0, 1, 0, 6,  ma, r, 1, 6, 6, 1, 0);
      add(0, 1, 0, 11, ma, r, 1, 11, 11, 1, 0);
      add(0, 1, 0, 13, ma, r, 1, 0, 11, 0, 0);
      add(0, 1, 0, 0,  ma, r, 1, 0, 0, 1, 0);
      add(0, 1, 0, 3,  ma, ramp(3), 1, 15, 3, 1, 0);
      // Scan 0,2,5,7,0 with dwell 3; wrap on 7->0
      for (int c = 0; c < 3; c++) sa(ma, r, 0, 0, 0);
      for (int c = 0; c < 3; c++) sa(ma, r, 2, 2, 0);
      for (int c = 0; c < 3; c++) sa(ma, r, 5, 5, 0);
      for (int c = 0; c < 3; c++) sa(ma, r, 7, 7, 0);
      sa(ma, r, 0, 0, 1);
      sa(ma, r, 0, 0, 0);
      sa(ma, ramp(0), 15, 0, 0);             // data tracks input
      // Mask changes mid-dwell
      sa(16'h0800, r, 11, 11, 0);
      sa(16'h0008, r, 11, 11, 0);            // own bit cleared, dwell completes
      sa(16'h0008, r, 11, 11, 0);
      sa(16'h0008, r, 3, 3, 1);
      sa(16'h0008, r, 3, 3, 0);
      sa(16'h0008, r, 3, 3, 0);
      sa(16'h0008, r, 3, 3, 1);              // single channel wraps every dwell
      // Empty mask, then single channel
      add(0, 1, 1, 0, 16'h0000, r, 0, 0, 3, 0, 0);
      add(0, 1, 1, 0, 16'h0000, r, 0, 0, 3, 0, 0);
      sa(16'h0010, r, 4, 4, 0);
      sa(16'h0010, r, 4, 4, 0);
      sa(16'h0010, r, 4, 4, 0);
      sa(16'h0010, r, 4, 4, 1);
      sa(16'h0010, r, 4, 4, 0);
      sa(16'h0010, r, 4, 4, 0);
      sa(16'h0010, r, 4, 4, 1);
      // Mode switching
      sa(ma, r, 4, 4, 0);
      sa(ma, r, 4, 4, 0);
      sa(ma, r, 5, 5, 0);
      sa(ma, r, 5, 5, 0);
      add(0, 1, 0, 1, ma, r, 1, 1, 1, 1, 0); // SCAN -> MAN mid-dwell
      sa(ma, r, 0, 0, 0);                    // MAN -> SCAN restarts
      sa(ma, r, 0, 0, 0);
      sa(ma, r, 0, 0, 0);
      sa(ma, r, 2, 2, 0);
      sa(ma, r, 2, 2, 0);
      // Enable low mid-dwell, then re-enable
      add(0, 0, 1, 0, ma, r, 1, 2, 2, 0, 0);
      add(0, 0, 1, 0, ma, ramp(2), 1, 2, 2, 0, 0);
      sa(ma, r, 0, 0, 0);
      sa(ma, r, 0, 0, 0);
      sa(ma, r, 0, 0, 0);
      sa(ma, r, 2, 2, 0);
      // DUT B: walking one across 16 channels
      for (int k = 0; k < 16; k++) begin
         add(1, 1, 0, k, 16'h0000, 48'(1) << k, 1, 1, k, 1, 0);
         add(1, 1, 0, (k + 1) % 16, 16'h0000, 48'(1) << k, 1, 0, (k + 1) % 16, 1, 0);
      end
      // DUT B: DWELL=1 scan over channels 0 and 15
      add(1, 1, 1, 0, 16'h8001, 48'h8000, 1, 0, 0, 1, 0);
      add(1, 1, 1, 0, 16'h8001, 48'h8000, 1, 1, 15, 1, 0);
      add(1, 1, 1, 0, 16'h8001, 48'h8000, 1, 0, 0, 1, 1);
      add(1, 1, 1, 0, 16'h8001, 48'h8000, 1, 1, 15, 1, 0);

      // Reset
      rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; mask = '0; data = '0;
      repeat (2) @(negedge clk);
      check("rst_dout_a", -1, 32'(dout_a), 32'd0);
      check("rst_ch_a", -1, 32'(ch_a), 32'd0);
      check("rst_valid_a", -1, 32'(valid_a), 32'd0);
      check("rst_wrap_a", -1, 32'(wrap_a), 32'd0);
      check("rst_valid_b", -1, 32'(valid_b), 32'd0);
      rst = 1'b0;

      // Table: stimulus pushes the expectation, the sample after the edge pops it
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         en = tbl[i].en; mode = tbl[i].mode; sel = tbl[i].sel;
         mask = tbl[i].mask; data = tbl[i].data;
         sb.push_back(tbl[i]);
         @(posedge clk);
         #1;
         ev = sb.pop_front();
         if (!ev.tgt) begin
            if (ev.chk_d) check("dout_a", i, 32'(dout_a), 32'(ev.e_dout));
            check("ch_a", i, 32'(ch_a), 32'(ev.e_ch));
            check("valid_a", i, 32'(valid_a), 32'(ev.e_valid));
            check("wrap_a", i, 32'(wrap_a), 32'(ev.e_wrap));
`ifdef MUX_SCAN_PARITY_EN
            if (ev.chk_d) check("par_a", i, 32'(par_a), 32'(^ev.e_dout));
`endif
         end else begin
            if (ev.chk_d) check("dout_b", i, 32'(dout_b), 32'(ev.e_dout));
            check("ch_b", i, 32'(ch_b), 32'(ev.e_ch));
            check("valid_b", i, 32'(valid_b), 32'(ev.e_valid));
            check("wrap_b", i, 32'(wrap_b), 32'(ev.e_wrap));
`ifdef MUX_SCAN_PARITY_EN
            if (ev.chk_d) check("par_b", i, 32'(par_b), 32'(ev.e_dout[0]));
`endif
         end
      end

      // Asynchronous reset between edges while scanning DUT A
      @(negedge clk);
      en = 1'b1; mode = 1'b1; mask = ma; data = r;
      @(negedge clk);                        // re-entry at channel 0
      mode = 1'b0; sel = 4'd7;
      @(negedge clk);
      mode = 1'b1;                           // MAN -> SCAN: channel 0
      repeat (4) @(posedge clk);
      #1;
      check("pre_rst_ch_a", -2, 32'(ch_a), 32'd2);
      check("pre_rst_dout_a", -2, 32'(dout_a), 32'd2);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_dout_a", -2, 32'(dout_a), 32'd0);
      check("async_rst_ch_a", -2, 32'(ch_a), 32'd0);
      check("async_rst_valid_a", -2, 32'(valid_a), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      mask = 16'h00A4;                       // lowest enabled now channel 2
      @(posedge clk);
      #1;
      check("post_rst_ch_a", -2, 32'(ch_a), 32'd2);
      check("post_rst_valid_a", -2, 32'(valid_a), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_adv_ch_a", -2, 32'(ch_a), 32'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_scan_nto1.md
Name: mux_scan_nto1

Overview:
- Parametrised, registered N:1 multiplexer; successor to the fixed 16:1 combinational mux.
- Two modes:
  - Manual select.
  - Auto-scan: steps round-robin through a channel-enable mask, holding each channel for a programmable dwell time.
- Feeds downstream sampling/serialising logic with the selected data, the channel index, a valid flag and a wrap pulse.

Parameters:
- CH, 16, number of input channels (2..64).
- W, 1, data width per channel in bits.
- DWELL, 1, clock cycles each channel is held in scan mode (1..256).
- CW, $clog2(CH), channel index width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  block enable; low freezes state and deasserts valid.
- mode  in  1  0 = manual select, 1 = auto-scan.
- sel  in  CW  channel index used in manual mode.
- mask  in  CH  per-channel scan enable (bit i = channel i); ignored in manual mode.
- data_in  in  CH*W  packed inputs; channel i occupies bits [i*W +: W].
- dout  out  W  registered selected data.
- ch_out  out  CW  index of the channel currently driving dout.
- valid  out  1  dout/ch_out are meaningful this cycle.
- wrap  out  1  one-cycle pulse when the scan returns from the highest to the lowest enabled channel.

Behaviour:
- Reset (async assert, sync deassert on clk): dout=0, ch_out=0, valid=0, wrap=0, dwell counter=0, state=IDLE.
- FSM states:
  - IDLE: entered on reset or while en=0.
  - MAN: entered when en=1 and mode=0.
  - SCAN: entered when en=1 and mode=1.
  - Transitions are evaluated every cycle from the (en, mode) pair.
- IDLE:
  - dout and ch_out hold their last values; valid=0, wrap=0.
  - Dwell counter is cleared.
- MAN:
  - One-cycle latency: dout <= data_in[sel], ch_out <= sel, valid <= 1.
  - sel >= CH (non-power-of-two CH): dout <= 0, valid <= 0, ch_out holds.
- SCAN entry (from IDLE or MAN):
  - ch_out <= lowest set bit of mask; dwell counter cleared; valid <= 1.
- SCAN steady state:
  - dout <= data_in[ch_out] every cycle, so data tracks input changes with 1-cycle latency.
  - Dwell counter counts 0..DWELL-1. At DWELL-1, ch_out advances to the next set mask bit above ch_out, circularly, and the counter clears.
  - wrap=1 for the single cycle in which the new index <= the old index (circular wrap). This includes the single-enabled-channel case, where wrap pulses every DWELL cycles.
- DWELL=1: channel advances every cycle.
- mask all zeros in SCAN: valid=0, ch_out holds, counter held at 0, wrap=0.
  - When a bit is later set, scanning resumes at the lowest set bit on the next cycle.
- Mask change mid-dwell: the current channel finishes its dwell even if its own bit was cleared; the next channel is chosen from the new mask.
- Mode change SCAN->MAN: the manual selection takes effect on the next cycle. Mode change MAN->SCAN restarts the scan at the lowest set bit.
- en=0 mid-dwell: counter cleared; on re-enable, behaviour is as for SCAN entry.
- rst mid-operation: outputs go to reset values immediately, regardless of clk.

Optional Feature:
- Macro MUX_SCAN_PARITY_EN.
- Defined:
  - Adds output par (1 bit), registered alongside dout.
  - par = even parity (XOR-reduce) of the selected data; reset value 0.
  - In MAN with an out-of-range sel, par <= 0.
- Undefined: port par absent; no parity logic.

Decomposition:
- Package mux_scan_pkg:
  - State enum (IDLE, MAN, SCAN) as a 2-bit typedef.
  - Localparams for mode encodings (MODE_MAN=0, MODE_SCAN=1).
  - Function first_set(mask) returning the lowest set index.
- Sub-module mux_next_ch:
  - Purely combinational circular priority search.
  - Inputs: mask, current index. Outputs: next index, any_set, wrapped.
  - Instantiated once, parametrised on CH.

Test Plan:
1. Reset and manual select: rst pulse, then en=1, mode=0, CH=16, W=1, channel 5 input=1 and all others 0. sel=5 -> dout=1, ch_out=5, valid=1 one cycle later. sel=6 -> dout=0 next cycle. Repeat the walking pattern across all 16 channels (E0..E15 equivalent).
2. Scan with dwell: CH=8, W=4, DWELL=3, data_in[i]=i, mask=8'b1010_0101.
   - Required ch_out sequence: 0,2,5,7,0 with each value held 3 cycles; dout matches the index.
   - wrap pulses exactly once, on the 7->0 transition.
3. Empty and single-channel mask: in SCAN, mask=0 -> valid=0 and ch_out frozen. Set mask=8'b0001_0000 -> ch_out=4, valid=1 next cycle, wrap pulses every DWELL cycles.
4. Mode and enable switching:
   - SCAN at ch_out=5 mid-dwell, switch mode=0 with sel=1 -> ch_out=1 next cycle.
   - Switch back to mode=1 -> ch_out = lowest set bit.
   - en=0 -> valid=0 and dout held.
5. Asynchronous reset mid-scan: assert rst between clock edges -> dout=0, ch_out=0, valid=0 before the next edge. After release, scanning restarts from the lowest set bit.
6. Out-of-range sel and parity: CH=12, sel=13 -> valid=0, dout=0. With MUX_SCAN_PARITY_EN, W=4, selected data 4'b1011 -> par=1.
